// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I core.
// Owns pc/instr, runs imem/dmem handshakes, traps stickily.
module rv_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      st;
  logic [7:0]  wait_cnt;
  logic [31:0] npc;

  logic [6:0]  opc;
  logic        legal;
  logic        writes_rd;
  logic        rd_nz;
  logic        is_mem;
  logic        is_store;
  logic [1:0]  sel_c;
  logic [31:0] npc_c;
  logic [31:0] pc_plus4;
  logic [31:0] pc_imm;
  logic        tmo;
  logic        unused_alu_lsb;

  assign opc       = instr[6:0];
  assign rd_nz     = (instr[11:7] != 5'd0);
  assign is_store  = (opc == OP_STORE);
  assign is_mem    = (opc == OP_LOAD) || is_store;
  assign pc_plus4  = pc + 32'd4;
  assign pc_imm    = pc + imm;
  assign tmo       = (wait_cnt == TMO_LAST);
  assign unused_alu_lsb = alu_result[0];

  // Opcode class decode of the latched instruction
  always_comb begin
    legal     = 1'b0;
    writes_rd = 1'b0;
    sel_c     = 2'd0;
    case (opc)
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LOAD: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        sel_c     = 2'd1;
      end
      OP_STORE, OP_BRANCH: begin
        legal     = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        sel_c     = 2'd2;
      end
      default: begin
        legal     = 1'b0;
      end
    endcase
    if (instr[1:0] != 2'b11) legal = 1'b0;
  end

  // Next-pc selection, evaluated while in EXEC
  always_comb begin
    npc_c = pc_plus4;
    if (opc == OP_JAL)
      npc_c = pc_imm;
    else if (opc == OP_JALR)
      npc_c = {alu_result[31:1], 1'b0};
    else if (opc == OP_BRANCH && branch_taken)
      npc_c = pc_imm;
  end

  // Fetch request is a pure function of state, held off during reset
  assign imem_req  = (st == FETCH) & ~rst;
  assign imem_addr = pc;
  assign state     = st;

  // Sequencer: state, pc/instr, handshakes and writeback strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= FETCH;
      pc         <= RESET_PC;
      instr      <= NOP;
      trap       <= 1'b0;
      retire_cnt <= 32'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      rf_we      <= 1'b0;
      wb_sel     <= 2'd0;
      wait_cnt   <= 8'd0;
      npc        <= 32'd0;
    end else begin
      rf_we <= 1'b0;
      case (st)
        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            wait_cnt <= 8'd0;
            st       <= DECODE;
          end else if (tmo) begin
            wait_cnt <= 8'd0;
            trap     <= 1'b1;
            st       <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          if (legal) begin
            st <= EXEC;
          end else begin
            trap <= 1'b1;
            st   <= TRAP;
          end
        end
        EXEC: begin
          dmem_addr <= alu_result;
          npc       <= npc_c;
          if (npc_c[1:0] != 2'b00) begin
            trap <= 1'b1;
            st   <= TRAP;
          end else if (is_mem) begin
            dmem_req <= 1'b1;
            dmem_we  <= is_store;
            st       <= MEM;
          end else begin
            rf_we  <= writes_rd & rd_nz;
            wb_sel <= sel_c;
            st     <= WB;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wait_cnt <= 8'd0;
            rf_we    <= writes_rd & rd_nz;
            wb_sel   <= sel_c;
            st       <= WB;
          end else if (tmo) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wait_cnt <= 8'd0;
            trap     <= 1'b1;
            st       <= TRAP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          pc         <= npc;
          retire_cnt <= retire_cnt + 32'd1;
          wb_sel     <= 2'd0;
          st         <= FETCH;
        end
        TRAP: begin
          st <= TRAP;
        end
        default: begin
          trap <= 1'b1;
          st   <= TRAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl.
// Scoreboard of expected retirements checked at each WB.
module tb_rv_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic        dmem_ack;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        trap;
  logic [31:0] retire_cnt;

  rv_multicycle_ctrl #(
    .RESET_PC(32'h0000_0000),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ack(imem_ack),
    .instr(instr),
    .imm(imm),
    .alu_result(alu_result),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_ack(dmem_ack),
    .rf_we(rf_we),
    .wb_sel(wb_sel),
    .pc(pc),
    .state(state),
    .trap(trap),
    .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        rf;
    logic [1:0]  sel;
    logic [31:0] npc;
    logic [31:0] rc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_rc;
  logic        pend = 1'b0;
  logic [31:0] pend_pc;
  logic [31:0] pend_rc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // WB monitor: pop expectation, then check pc/retire next cycle
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("wb_pc", pc, pend_pc);
        chk("wb_retire", retire_cnt, pend_rc);
        pend = 1'b0;
      end
      if (state == 3'd4) begin
        chk("sb_size", 32'(sbq.size()), 32'd1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("wb_rf_we", {31'd0, rf_we}, {31'd0, e.rf});
          chk("wb_sel", {30'd0, wb_sel}, {30'd0, e.sel});
          pend    = 1'b1;
          pend_pc = e.npc;
          pend_rc = e.rc;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    sbq.delete();
    exp_rc = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] w,
                       input int iw,
                       output int cyc);
    cyc = 0;
    #1;
    chk("imem_req", {31'd0, imem_req}, 32'd1);
    chk("imem_addr", imem_addr, pc);
    for (int k = 0; k <= iw; k++) begin
      imem_ack   = (k == iw);
      imem_rdata = w;
      @(negedge clk);
      cyc++;
    end
    imem_ack = 1'b0;
    chk("st_decode", {29'd0, state}, 32'd1);
  endtask

  // mode 0: retire, 1: trap in DECODE, 2: trap in EXEC
  task automatic run(input logic [31:0] w,
                     input logic [31:0] imm_v,
                     input logic [31:0] alu_v,
                     input logic bt,
                     input int iw,
                     input int dw,
                     input logic ewe,
                     input int mode,
                     input logic erf,
                     input logic [1:0] esel,
                     input logic [31:0] enpc,
                     output int cyc);
    int nreq;
    if (mode == 0) begin
      exp_t e;
      exp_rc = exp_rc + 32'd1;
      e.rf = erf;
      e.sel = esel;
      e.npc = enpc;
      e.rc = exp_rc;
      sbq.push_back(e);
    end
    fetch(w, iw, cyc);
    imm = imm_v;
    alu_result = alu_v;
    branch_taken = bt;
    @(negedge clk);
    cyc++;
    if (mode == 1) begin
      chk("trap_dec_st", {29'd0, state}, 32'd7);
      chk("trap_dec_flag", {31'd0, trap}, 32'd1);
      return;
    end
    chk("st_exec", {29'd0, state}, 32'd2);
    @(negedge clk);
    cyc++;
    if (mode == 2) begin
      chk("trap_ex_st", {29'd0, state}, 32'd7);
      chk("trap_ex_flag", {31'd0, trap}, 32'd1);
      return;
    end
    if (dw >= 0) begin
      nreq = 0;
      chk("st_mem", {29'd0, state}, 32'd3);
      chk("dmem_addr", dmem_addr, alu_v);
      chk("dmem_we", {31'd0, dmem_we}, {31'd0, ewe});
      for (int k = 0; k <= dw; k++) begin
        if (dmem_req) nreq++;
        dmem_ack = (k == dw);
        @(negedge clk);
        cyc++;
      end
      dmem_ack = 1'b0;
      chk("dmem_req_cyc", 32'(nreq), 32'(dw + 1));
      chk("dmem_req_off", {31'd0, dmem_req}, 32'd0);
    end
    chk("st_wb", {29'd0, state}, 32'd4);
    @(negedge clk);
    cyc++;
  endtask

  int cyc;
  int n;

  initial begin
    rst = 1'b1;
    imem_rdata = 32'd0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    imm = 32'd0;
    alu_result = 32'd0;
    branch_taken = 1'b0;
    exp_rc = 32'd0;
    @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    do_reset();

    // ADDI x1,x0,5 with two fetch wait cycles
    run(32'h00500093, 32'd5, 32'd5, 1'b0, 2, -1, 1'b0,
        0, 1'b1, 2'd0, 32'h4, cyc);
    chk("addi_cycles", 32'(cyc), 32'd6);
    // SW then LW at 0x100, dmem ack after 3 waits
    run(32'h0020a023, 32'd0, 32'h100, 1'b0, 0, 3, 1'b1,
        0, 1'b0, 2'd0, 32'h8, cyc);
    chk("sw_cycles", 32'(cyc), 32'd8);
    run(32'h0000a183, 32'd0, 32'h100, 1'b0, 1, 3, 1'b0,
        0, 1'b1, 2'd1, 32'hC, cyc);
    // JAL x0,+20 to reach 0x20
    run(32'h0000006f, 32'd20, 32'd0, 1'b0, 0, -1, 1'b0,
        0, 1'b0, 2'd2, 32'h20, cyc);
    // BEQ imm=-8, taken then not taken
    run(32'hfe208ce3, 32'hFFFF_FFF8, 32'd0, 1'b1, 0, -1, 1'b0,
        0, 1'b0, 2'd0, 32'h18, cyc);
    run(32'h0000006f, 32'd8, 32'd0, 1'b0, 0, -1, 1'b0,
        0, 1'b0, 2'd2, 32'h20, cyc);
    run(32'hfe208ce3, 32'hFFFF_FFF8, 32'd0, 1'b0, 0, -1, 1'b0,
        0, 1'b0, 2'd0, 32'h24, cyc);
    // JAL x0,+28 then JAL x1,+12 at 0x40
    run(32'h0000006f, 32'd28, 32'd0, 1'b0, 0, -1, 1'b0,
        0, 1'b0, 2'd2, 32'h40, cyc);
    run(32'h00c000ef, 32'd12, 32'd0, 1'b0, 0, -1, 1'b0,
        0, 1'b1, 2'd2, 32'h4C, cyc);
    // ADDI x0 (no write) and LUI x5
    run(32'h00000013, 32'd0, 32'd0, 1'b0, 0, -1, 1'b0,
        0, 1'b0, 2'd0, 32'h50, cyc);
    run(32'h123452b7, 32'h1234_5000, 32'h1234_5000, 1'b0, 0, -1,
        1'b0, 0, 1'b1, 2'd0, 32'h54, cyc);
    // JALR to 0x103 -> target 0x102 misaligned
    run(32'h000080e7, 32'd0, 32'h103, 1'b0, 0, -1, 1'b0,
        2, 1'b0, 2'd0, 32'h0, cyc);
    chk("jalr_pc_frozen", pc, 32'h54);
    chk("jalr_instr", instr, 32'h000080e7);
    chk("jalr_retire", retire_cnt, exp_rc);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk("trap_sticky_st", {29'd0, state}, 32'd7);
    chk("trap_imem_req", {31'd0, imem_req}, 32'd0);
    chk("trap_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("trap_pc", pc, 32'h54);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // Illegal opcode 7'b1111111
    do_reset();
    run(32'h0000007f, 32'd0, 32'd0, 1'b0, 0, -1, 1'b0,
        1, 1'b0, 2'd0, 32'h0, cyc);
    chk("illegal_pc", pc, 32'h0);
    chk("illegal_instr", instr, 32'h0000007f);
    chk("illegal_retire", retire_cnt, 32'd0);

    // Fetch timeout with no imem_ack
    do_reset();
    n = 0;
    while (n <= 40) begin
      @(negedge clk);
      n++;
      if (state == 3'd7) break;
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_trap", {31'd0, trap}, 32'd1);

    // Reset during the MEM wait aborts at once
    do_reset();
    run(32'h00500093, 32'd5, 32'd5, 1'b0, 0, -1, 1'b0,
        0, 1'b1, 2'd0, 32'h4, cyc);
    fetch(32'h0000a183, 0, cyc);
    alu_result = 32'h200;
    imm = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_mem", {29'd0, state}, 32'd3);
    chk("abort_req_on", {31'd0, dmem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_pc", pc, 32'd0);
    chk("abort_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("abort_retire", retire_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Owns the PC and the instruction register, and runs the instruction and data memory handshakes.
- Feeds the latched instruction to the instruction decoder and sequences ALU, memory and register-file writeback, one instruction at a time.
- Flags illegal opcodes, misaligned control-flow targets and memory timeouts by entering a sticky trap state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_TIMEOUT, 16, max cycles waiting for imem_ack/dmem_ack before trap; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_rdata  in  32  fetched word, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- instr  out  32  latched instruction register, to decoder
- imm  in  32  decoded immediate from decoder
- alu_result  in  32  ALU output; load/store address and JALR target
- branch_taken  in  1  branch comparator result, valid in EXEC
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  32  = alu_result, registered in EXEC
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe, one cycle
- wb_sel  out  2  0=ALU, 1=load data, 2=pc+4
- pc  out  32  current instruction address
- state  out  3  FSM state, for debug
- trap  out  1  sticky trap flag
- retire_cnt  out  32  retired instruction count

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, instr=32'h0000_0013 (NOP), state=FETCH, trap=0, retire_cnt=0.
  - All request and strobe outputs are 0; wb_sel=0; dmem_addr=0.
  - Reset asserted mid-handshake aborts immediately, with no retire.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH:
  - imem_req=1 and imem_addr=pc, held until imem_ack.
  - On imem_ack: instr<=imem_rdata, go to DECODE.
  - A wait counter clears on state entry. If it reaches MEM_TIMEOUT without ack, go to TRAP.
- DECODE:
  - One cycle for the decoder to settle.
  - Legal opcodes (instr[6:0]): 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111.
  - Any other opcode, or instr[1:0]!=2'b11, goes to TRAP.
- EXEC:
  - One cycle. Registers dmem_addr<=alu_result.
  - Computes next_pc:
    - JAL: pc+imm.
    - JALR: {alu_result[31:1],1'b0}.
    - BRANCH: branch_taken ? pc+imm : pc+4.
    - All others: pc+4.
  - If next_pc[1:0]!=0, go to TRAP; pc is not updated.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM:
  - dmem_req=1, dmem_we=(opcode==STORE), held stable until dmem_ack.
  - On ack go to WB. Timeout goes to TRAP, as in FETCH.
- WB:
  - rf_we=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR when instr[11:7]!=0; otherwise 0.
  - wb_sel: LOAD=1; JAL/JALR=2; else 0.
  - pc<=next_pc, retire_cnt<=retire_cnt+1 (wraps 2^32-1 to 0), go to FETCH.
- TRAP:
  - trap=1, all requests and strobes 0.
  - pc and instr frozen at the faulting instruction; remains here until rst.
- Latency: non-memory instruction 4 cycles + fetch wait; load/store 5 cycles + both waits.
- An ack arriving while the FSM is not in the matching wait state is ignored.
- next_pc arithmetic is modulo 2^32; wrap past 32'hFFFF_FFFC is legal.

Test Plan:
- Reset then ADDI x1,x0,5 (32'h00500093), imem_ack after 2 wait cycles:
  - imem_addr=0.
  - rf_we pulses in WB with wb_sel=0.
  - pc=4, retire_cnt=1.
  - 6 cycles total from reset release.
- STORE then LOAD at alu_result=32'h100, dmem_ack delayed 3 cycles:
  - dmem_req held 4 cycles with dmem_we=1 then 0.
  - Load WB has wb_sel=1.
  - No rf_we on the store.
- BEQ with imm=-8 at pc=32'h20:
  - branch_taken=1 gives pc=32'h18.
  - branch_taken=0 gives pc=32'h24.
  - rf_we=0 in both cases.
- JAL x1,+12 at pc=32'h40: pc=32'h4C, rf_we=1, wb_sel=2. JALR with alu_result=32'h103: pc=32'h102 is misaligned, so trap=1 and state=7.
- Faults:
  - Opcode 7'b1111111 traps in DECODE.
  - imem_ack never asserted traps after 16 cycles with MEM_TIMEOUT=16.
  - Asserting rst during the MEM wait clears state to FETCH, pc=RESET_PC, dmem_req=0 in the same cycle.
